// File: rtl/burst_unalign_if.sv
// Handshake bundle between the write-path unaligner, the unit's output FIFO
// and the AXI write-data channel. The slave modport is the unaligner's view.
interface burst_unalign_if #(
    parameter int AXI_DATA_W = 32
);
    localparam int OFFSET_W = $clog2(AXI_DATA_W / 8);
    localparam int STRB_W   = AXI_DATA_W / 8;

    logic [OFFSET_W-1:0]   offset_i;
    logic                  start_i;
    logic [AXI_DATA_W-1:0] data_in_i;
    logic                  valid_in_i;
    logic                  last_in_i;
    logic                  ready_in_o;
    logic [AXI_DATA_W-1:0] data_out_o;
    logic [STRB_W-1:0]     strb_out_o;
    logic                  valid_out_o;
    logic                  last_out_o;
    logic                  ready_out_i;
    logic                  busy_o;

    modport slave (
        input  offset_i, start_i, data_in_i, valid_in_i, last_in_i, ready_out_i,
        output ready_in_o, data_out_o, strb_out_o, valid_out_o, last_out_o, busy_o
    );

    modport master (
        output offset_i, start_i, data_in_i, valid_in_i, last_in_i, ready_out_i,
        input  ready_in_o, data_out_o, strb_out_o, valid_out_o, last_out_o, busy_o
    );
endinterface

// File: rtl/burst_unalign.sv
// Write-path unaligner: shifts word-aligned input data up to a destination
// byte offset, stitching each beat from the current word and the previous one,
// and emits one trailing flush beat for the residual bytes of an unaligned
// transfer. Data beats are combinational from the input (zero latency).
module burst_unalign #(
    parameter int AXI_DATA_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    burst_unalign_if.slave   bus
);
    localparam int OFFSET_W = $clog2(AXI_DATA_W / 8);
    localparam int STRB_W   = AXI_DATA_W / 8;
    localparam int SH_W     = $clog2(AXI_DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [OFFSET_W-1:0]   off_q, off_d;
    logic [AXI_DATA_W-1:0] stored_q, stored_d;

    logic [SH_W-1:0]       sh_up;
    logic [SH_W-1:0]       sh_dn;
    logic [AXI_DATA_W-1:0] up_word;
    logic [AXI_DATA_W-1:0] carry_word;

    logic                  ready_in;
    logic                  valid_out;
    logic                  last_out;
    logic [AXI_DATA_W-1:0] data_out;
    logic [STRB_W-1:0]     strb_out;

    // Shift amounts in bits; the carry term is forced to zero at offset 0 so
    // the previous word is never shifted by the full data width.
    assign sh_up      = SH_W'({off_q, 3'b000});
    assign sh_dn      = SH_W'(AXI_DATA_W) - sh_up;
    assign up_word    = bus.data_in_i << sh_up;
    assign carry_word = (off_q == '0) ? '0 : (stored_q >> sh_dn);

    // Next-state and beat generation; start_i overrides everything and blanks
    // both handshakes for its cycle.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        stored_d  = stored_q;
        ready_in  = 1'b0;
        valid_out = 1'b0;
        last_out  = 1'b0;
        data_out  = '0;
        strb_out  = '0;

        if (bus.start_i) begin
            state_d  = FIRST;
            off_d    = bus.offset_i;
            stored_d = '0;
        end else begin
            case (state_q)
                FIRST, STREAM: begin
                    ready_in  = bus.ready_out_i;
                    valid_out = bus.valid_in_i;
                    if (state_q == FIRST) begin
                        data_out = up_word;
                        strb_out = {STRB_W{1'b1}} << off_q;
                    end else begin
                        data_out = up_word | carry_word;
                        strb_out = {STRB_W{1'b1}};
                    end
                    last_out = bus.valid_in_i && bus.last_in_i && (off_q == '0);
                    if (bus.valid_in_i && bus.ready_out_i) begin
                        stored_d = bus.data_in_i;
                        if (bus.last_in_i) begin
                            state_d = (off_q == '0) ? IDLE : FLUSH;
                        end else begin
                            state_d = STREAM;
                        end
                    end
                end
                FLUSH: begin
                    valid_out = 1'b1;
                    last_out  = 1'b1;
                    data_out  = carry_word;
                    strb_out  = (STRB_W'(1) << off_q) - STRB_W'(1);
                    if (bus.ready_out_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end

        // Bus is quiet whenever no beat is offered.
        if (!valid_out) begin
            data_out = '0;
            strb_out = '0;
        end
    end

    // State, latched offset and previous-word registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            off_q    <= '0;
            stored_q <= '0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            stored_q <= stored_d;
        end
    end

    assign bus.ready_in_o  = ready_in;
    assign bus.valid_out_o = valid_out;
    assign bus.last_out_o  = last_out;
    assign bus.data_out_o  = data_out;
    assign bus.strb_out_o  = strb_out;
    assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_burst_unalign.sv
// Self-checking bench for burst_unalign (32-bit bus). Expected beats come from
// a byte-stream model: the destination stream is offset zero bytes followed by
// the input bytes, cut into 4-byte beats.
module tb_burst_unalign;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [31:0] words[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_strb[$];
    logic        exp_last[$];

    burst_unalign_if #(.AXI_DATA_W(32)) bus ();

    burst_unalign #(.AXI_DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte-stream reference for the current words queue at a given offset.
    task automatic build_expected(input int off);
        int n;
        int total;
        int nb;
        int pos;
        int k;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] w;
        n     = words.size();
        total = off + 4 * n;
        nb    = (total + 3) / 4;
        exp_data.delete();
        exp_strb.delete();
        exp_last.delete();
        for (int b = 0; b < nb; b++) begin
            d = '0;
            s = '0;
            for (int j = 0; j < 4; j++) begin
                pos = b * 4 + j;
                if (pos >= off && pos < total) begin
                    k = pos - off;
                    w = words[k / 4];
                    d[8*j +: 8] = w[8*(k % 4) +: 8];
                    s[j] = 1'b1;
                end
            end
            exp_data.push_back(d);
            exp_strb.push_back(s);
            exp_last.push_back(b == nb - 1);
        end
    endtask

    task automatic drive_idle();
        bus.start_i     = 1'b0;
        bus.offset_i    = '0;
        bus.valid_in_i  = 1'b0;
        bus.last_in_i   = 1'b0;
        bus.data_in_i   = '0;
        bus.ready_out_i = 1'b1;
    endtask

    // Full transfer of the words queue at offset off. bp_mode: 0 = sink always
    // ready, 1 = random sink stalls, 2 = periodic 3-cycle sink stalls.
    task automatic run_transfer(input int off, input int bp_mode, input string name);
        logic [31:0] got_d[$];
        logic [3:0]  got_s[$];
        logic        got_l[$];
        int          idx;
        int          cyc;
        bit          hold;
        bit          prev_stall;
        logic [31:0] prev_d;
        logic [3:0]  prev_s;
        logic        prev_l;
        int          nmin;

        build_expected(off);
        @(posedge clk); #1;
        bus.start_i     = 1'b1;
        bus.offset_i    = 2'(off);
        bus.valid_in_i  = 1'b1;
        bus.data_in_i   = $urandom;
        bus.last_in_i   = 1'b0;
        bus.ready_out_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ready_in_o !== 1'b0 || bus.valid_out_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_cycle: ready_in=%b valid_out=%b, required 0 0",
                     name, bus.ready_in_o, bus.valid_out_o);
        end
        @(posedge clk); #1;
        bus.start_i    = 1'b0;
        bus.valid_in_i = 1'b0;

        idx = 0; cyc = 0; hold = 0; prev_stall = 0;
        prev_d = '0; prev_s = '0; prev_l = 1'b0;
        while (got_d.size() < exp_data.size() && cyc < 400) begin
            if (!hold) begin
                if (idx < words.size() && $urandom_range(0, 3) != 0) begin
                    bus.valid_in_i = 1'b1;
                    bus.data_in_i  = words[idx];
                    bus.last_in_i  = (idx == words.size() - 1);
                end else begin
                    bus.valid_in_i = 1'b0;
                    bus.data_in_i  = $urandom;
                    bus.last_in_i  = 1'($urandom_range(0, 1));
                end
            end
            case (bp_mode)
                0:       bus.ready_out_i = 1'b1;
                1:       bus.ready_out_i = ($urandom_range(0, 2) != 0);
                default: bus.ready_out_i = ((cyc % 6) >= 3);
            endcase
            @(negedge clk);
            if (cyc == 0) begin
                n_checks++;
                if (bus.busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_during: busy=%b, required 1", name, bus.busy_o);
                end
            end
            if (!bus.ready_out_i) begin
                n_checks++;
                if (bus.ready_in_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s ready_in_under_stall: ready_in=%b, required 0",
                             name, bus.ready_in_o);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (bus.valid_out_o !== 1'b1 || bus.data_out_o !== prev_d ||
                    bus.strb_out_o !== prev_s || bus.last_out_o !== prev_l) begin
                    n_fail++;
                    $display("FAIL %s stall_stable: v=%b d=%h s=%h l=%b, required v=1 d=%h s=%h l=%b",
                             name, bus.valid_out_o, bus.data_out_o, bus.strb_out_o,
                             bus.last_out_o, prev_d, prev_s, prev_l);
                end
            end
            prev_stall = (bus.valid_out_o === 1'b1) && !bus.ready_out_i;
            prev_d = bus.data_out_o;
            prev_s = bus.strb_out_o;
            prev_l = bus.last_out_o;
            if (bus.valid_out_o === 1'b1 && bus.ready_out_i) begin
                got_d.push_back(bus.data_out_o);
                got_s.push_back(bus.strb_out_o);
                got_l.push_back(bus.last_out_o);
                $display("%s beat %0d: data=%h strb=%h last=%b", name, got_d.size() - 1,
                         bus.data_out_o, bus.strb_out_o, bus.last_out_o);
            end
            hold = bus.valid_in_i && (bus.ready_in_o !== 1'b1);
            if (bus.valid_in_i && bus.ready_in_o === 1'b1) idx++;
            cyc++;
            @(posedge clk); #1;
        end
        if (cyc >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d beats, required %0d", name,
                     got_d.size(), exp_data.size());
        end

        bus.valid_in_i  = 1'b0;
        bus.ready_out_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.valid_out_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_idle: busy=%b valid_out=%b, required 0 0 (extra beat?)",
                     name, bus.busy_o, bus.valid_out_o);
        end

        n_checks++;
        if (got_d.size() != exp_data.size()) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d, required %0d", name,
                     got_d.size(), exp_data.size());
        end
        nmin = (got_d.size() < exp_data.size()) ? got_d.size() : exp_data.size();
        for (int i = 0; i < nmin; i++) begin
            n_checks++;
            if (got_d[i] !== exp_data[i] || got_s[i] !== exp_strb[i] || got_l[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL %s beat%0d: d=%h s=%h l=%b, required d=%h s=%h l=%b", name, i,
                         got_d[i], got_s[i], got_l[i], exp_data[i], exp_strb[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.valid_out_o !== 1'b0 || bus.ready_in_o !== 1'b0 || bus.last_out_o !== 1'b0 ||
            bus.busy_o !== 1'b0 || bus.data_out_o !== 32'h0 || bus.strb_out_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_values: v=%b r=%b l=%b b=%b d=%h s=%h, required all 0",
                     bus.valid_out_o, bus.ready_in_o, bus.last_out_o, bus.busy_o,
                     bus.data_out_o, bus.strb_out_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.valid_in_i = 1'b1;
        bus.data_in_i  = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if (bus.ready_in_o !== 1'b0 || bus.valid_out_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_input: ready_in=%b valid_out=%b, required 0 0",
                     bus.ready_in_o, bus.valid_out_o);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_aligned();
        words = {32'h03020100, 32'h07060504, 32'h0B0A0908};
        run_transfer(0, 0, "aligned");
    endtask

    task automatic test_offset1();
        words = {32'h03020100, 32'h07060504, 32'h0B0A0908};
        run_transfer(1, 0, "offset1");
    endtask

    task automatic test_offset3();
        words = {32'hDDCCBBAA};
        run_transfer(3, 0, "offset3");
    endtask

    task automatic test_backpressure();
        words = {32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
        run_transfer(2, 2, "backpressure");
        words = {32'h11223344, 32'h55667788};
        run_transfer(1, 1, "backpressure_rand");
    endtask

    task automatic test_abort();
        words = {32'h44332211, 32'h88776655};
        build_expected(2);
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.offset_i = 2'd2;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.valid_in_i  = 1'b1;
            bus.data_in_i   = words[k];
            bus.last_in_i   = 1'b0;
            bus.ready_out_i = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.valid_out_o !== 1'b1 || bus.ready_in_o !== 1'b1 ||
                bus.data_out_o !== exp_data[k] || bus.strb_out_o !== exp_strb[k] ||
                bus.last_out_o !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_pre%0d: v=%b r=%b d=%h s=%h l=%b, required v=1 r=1 d=%h s=%h l=0",
                         k, bus.valid_out_o, bus.ready_in_o, bus.data_out_o,
                         bus.strb_out_o, bus.last_out_o, exp_data[k], exp_strb[k]);
            end
            $display("abort beat %0d: data=%h strb=%h", k, bus.data_out_o, bus.strb_out_o);
            @(posedge clk); #1;
        end
        bus.valid_in_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.valid_out_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_beat_without_input: valid_out=%b, required 0", bus.valid_out_o);
        end
        words = {$urandom, $urandom, $urandom};
        run_transfer(0, 0, "after_abort");
    endtask

    task automatic test_reset_in_flush();
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.offset_i = 2'd1;
        @(posedge clk); #1;
        bus.start_i     = 1'b0;
        bus.valid_in_i  = 1'b1;
        bus.data_in_i   = 32'hCAFEF00D;
        bus.last_in_i   = 1'b1;
        bus.ready_out_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_in_i  = 1'b0;
        bus.ready_out_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.valid_out_o !== 1'b1 || bus.last_out_o !== 1'b1 ||
            bus.data_out_o !== 32'h000000CA || bus.strb_out_o !== 4'h1) begin
            n_fail++;
            $display("FAIL flush_pending: v=%b l=%b d=%h s=%h, required v=1 l=1 d=000000ca s=1",
                     bus.valid_out_o, bus.last_out_o, bus.data_out_o, bus.strb_out_o);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.valid_out_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.last_out_o !== 1'b0 ||
            bus.data_out_o !== 32'h0 || bus.strb_out_o !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset_clear: v=%b b=%b l=%b d=%h s=%h, required all 0",
                     bus.valid_out_o, bus.busy_o, bus.last_out_o, bus.data_out_o, bus.strb_out_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.valid_in_i  = 1'b1;
        bus.data_in_i   = 32'h01020304;
        bus.ready_out_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ready_in_o !== 1'b0 || bus.valid_out_o !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle%0d: ready_in=%b valid_out=%b, required 0 0",
                         c, bus.ready_in_o, bus.valid_out_o);
            end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_random();
        int off;
        int n;
        for (int t = 0; t < 10; t++) begin
            off = $urandom_range(0, 3);
            n   = $urandom_range(1, 5);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_transfer(off, $urandom_range(0, 2), $sformatf("random%0d", t));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_idle();
        test_reset();
        test_aligned();
        test_offset1();
        test_offset3();
        test_backpressure();
        test_abort();
        test_reset_in_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
